// File: rtl/ts4231_multi_cfg.sv
// ts4231_multi_cfg
//   Configures up to N_CH TS4231 light-sensor front ends over their shared-style
//   two-wire D/E bus.
//   One sequencer visits the channels in order 0..N_CH-1. For each channel it:
//     - probes for E high,
//     - writes CFG_WORD,
//     - reads the word back and compares it,
//     - retries up to MAX_RETRY times on a mismatch.
//
// Ports
//   clk                     system clock, rising edge
//   reset                   synchronous, active-high
//   start                   one-cycle pulse, begins a run (ignored while busy)
//   d_in, e_in   [N_CH]     synchronised pad levels
//   d_out, d_oe  [N_CH]     D pad drive value / drive enable
//   e_out, e_oe  [N_CH]     E pad drive value / drive enable
//   busy                    run in progress
//   cfg_done                run complete, held until next start or reset
//   ch_ok, ch_fail [N_CH]   per-channel result
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | pads released, waiting for start
// PWR_WAIT | one power-up settle delay per run
// PROBE    | pads released, wait for sensor idx to show E high (bounded)
// START    | bus start condition (3 steps); r_rd selects what follows
// WRITE    | 15 config bits MSB first, 3 steps per bit
// STOP     | bus stop condition (3 steps); r_rd selects what follows
// READ     | D released, 15 readback bits MSB first, 2 steps per bit
// CHECK    | compare readback, retry or record result
// NEXT     | advance to the next channel or finish
// DONE     | flag cfg_done, drop busy
module ts4231_multi_cfg #(
  parameter int unsigned CLK_FREQ_HZ = 48_000_000,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned WAIT_US     = 10_000,
  parameter int unsigned BIT_TICKS   = 12,
  parameter logic [14:0] CFG_WORD    = 15'h392B,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned PROBE_US    = 100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [N_CH-1:0] d_in,
  input  logic [N_CH-1:0] e_in,
  output logic [N_CH-1:0] d_out,
  output logic [N_CH-1:0] d_oe,
  output logic [N_CH-1:0] e_out,
  output logic [N_CH-1:0] e_oe,
  output logic            busy,
  output logic            cfg_done,
  output logic [N_CH-1:0] ch_ok,
  output logic [N_CH-1:0] ch_fail
);

  // Delay products are formed in 64 bits and clamped, so a large
  // WAIT_US/PROBE_US saturates at the 32-bit maximum instead of wrapping.
  localparam logic [63:0] CLK_PER_US = 64'(CLK_FREQ_HZ / 1_000_000);
  localparam logic [63:0] WAIT_PROD  = 64'(WAIT_US) * CLK_PER_US;
  localparam logic [63:0] PROBE_PROD = 64'(PROBE_US) * CLK_PER_US;
  localparam logic [31:0] WAIT_CNT   = (WAIT_PROD > 64'h0000_0000_FFFF_FFFF) ?
                                       32'hFFFF_FFFF : WAIT_PROD[31:0];
  localparam logic [31:0] PROBE_CNT  = (PROBE_PROD > 64'h0000_0000_FFFF_FFFF) ?
                                       32'hFFFF_FFFF : PROBE_PROD[31:0];
  // The down-counters include their terminal cycle, so they are loaded with
  // N-1. This gives a state that lasts exactly N cycles.
  localparam logic [31:0] WAIT_LD    = (WAIT_CNT == 32'd0) ? 32'd0 : WAIT_CNT - 32'd1;
  localparam logic [31:0] PROBE_LD   = (PROBE_CNT == 32'd0) ? 32'd0 : PROBE_CNT - 32'd1;

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW = $clog2(BIT_TICKS);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TICK_LD = TW'(BIT_TICKS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_PROBE, S_START, S_WRITE,
    S_STOP, S_READ, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t          r_state;
  logic [31:0]     r_cnt;
  logic [TW-1:0]   r_tick;
  logic [1:0]      r_ph;
  logic [3:0]      r_bit;
  logic            r_rd;
  logic [RW-1:0]   r_retry;
  logic [IW-1:0]   r_idx;
  logic [14:0]     r_rx;
  logic            r_d, r_e, r_doe, r_eoe;
  logic            r_busy, r_done;
  logic [N_CH-1:0] r_ok, r_fail;

  logic            w_step_end;
  logic [3:0]      w_bit_m1;
  logic [N_CH-1:0] w_sel;

  assign w_step_end = (r_tick == '0);
  assign w_bit_m1   = r_bit - 4'd1;
  assign w_sel      = N_CH'(1) << r_idx;

  // Pad levels are held as single registered bits and steered to the
  // selected channel. As a result, at most one channel can ever be driven.
  assign d_out    = r_d   ? w_sel : '0;
  assign d_oe     = r_doe ? w_sel : '0;
  assign e_out    = r_e   ? w_sel : '0;
  assign e_oe     = r_eoe ? w_sel : '0;
  assign busy     = r_busy;
  assign cfg_done = r_done;
  assign ch_ok    = r_ok;
  assign ch_fail  = r_fail;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tick  <= '0;
      r_ph    <= '0;
      r_bit   <= '0;
      r_rd    <= 1'b0;
      r_retry <= '0;
      r_idx   <= '0;
      r_rx    <= '0;
      r_d     <= 1'b0;
      r_e     <= 1'b0;
      r_doe   <= 1'b0;
      r_eoe   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ok    <= '0;
      r_fail  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ok    <= '0;
            r_fail  <= '0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_retry <= '0;
            r_cnt   <= WAIT_LD;
            r_busy  <= 1'b1;
            r_state <= S_PWR_WAIT;
          end
        end

        S_PWR_WAIT: begin
          if (r_cnt == 32'd0) begin
            r_cnt   <= PROBE_LD;
            r_state <= S_PROBE;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end

        S_PROBE: begin
          if (e_in[r_idx]) begin
            r_rd    <= 1'b0;
            r_ph    <= 2'd0;
            r_tick  <= TICK_LD;
            r_doe   <= 1'b1;
            r_eoe   <= 1'b1;
            r_d     <= 1'b1;
            r_e     <= 1'b1;
            r_state <= S_START;
          end else if (r_cnt == 32'd0) begin
            r_fail[r_idx] <= 1'b1;
            r_state       <= S_NEXT;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end

        S_START: begin
          if (!w_step_end) begin
            r_tick <= r_tick - TW'(1);
          end else begin
            r_tick <= TICK_LD;
            case (r_ph)
              2'd0: begin r_d <= 1'b0; r_ph <= 2'd1; end
              2'd1: begin r_e <= 1'b0; r_ph <= 2'd2; end
              default: begin
                r_ph  <= 2'd0;
                r_bit <= 4'd14;
                if (r_rd) begin
                  // The first READ step releases D so the sensor can drive it.
                  r_doe   <= 1'b0;
                  r_d     <= 1'b0;
                  r_state <= S_READ;
                end else begin
                  r_d     <= CFG_WORD[14];
                  r_state <= S_WRITE;
                end
              end
            endcase
          end
        end

        S_WRITE: begin
          if (!w_step_end) begin
            r_tick <= r_tick - TW'(1);
          end else begin
            r_tick <= TICK_LD;
            case (r_ph)
              2'd0: begin r_e <= 1'b1; r_ph <= 2'd1; end
              2'd1: begin r_e <= 1'b0; r_ph <= 2'd2; end
              default: begin
                r_ph <= 2'd0;
                if (r_bit == 4'd0) begin
                  r_d     <= 1'b0;
                  r_e     <= 1'b1;
                  r_state <= S_STOP;
                end else begin
                  r_bit <= w_bit_m1;
                  r_d   <= CFG_WORD[w_bit_m1];
                end
              end
            endcase
          end
        end

        S_STOP: begin
          if (!w_step_end) begin
            r_tick <= r_tick - TW'(1);
          end else begin
            r_tick <= TICK_LD;
            case (r_ph)
              2'd0: begin r_d <= 1'b1; r_ph <= 2'd1; end
              2'd1: begin
                r_doe <= 1'b0;
                r_eoe <= 1'b0;
                r_d   <= 1'b0;
                r_e   <= 1'b0;
                r_ph  <= 2'd2;
              end
              default: begin
                r_ph <= 2'd0;
                if (r_rd) begin
                  r_state <= S_CHECK;
                end else begin
                  // Write is finished, so open the readback transaction.
                  r_rd    <= 1'b1;
                  r_doe   <= 1'b1;
                  r_eoe   <= 1'b1;
                  r_d     <= 1'b1;
                  r_e     <= 1'b1;
                  r_state <= S_START;
                end
              end
            endcase
          end
        end

        S_READ: begin
          // ph0: D release step, ph1: E high, ph2: E low
          if (!w_step_end) begin
            r_tick <= r_tick - TW'(1);
          end else begin
            r_tick <= TICK_LD;
            case (r_ph)
              2'd0: begin r_e <= 1'b1; r_ph <= 2'd1; end
              2'd1: begin
                r_rx <= {r_rx[13:0], d_in[r_idx]};
                r_e  <= 1'b0;
                r_ph <= 2'd2;
              end
              default: begin
                if (r_bit == 4'd0) begin
                  r_ph    <= 2'd0;
                  r_doe   <= 1'b1;
                  r_d     <= 1'b0;
                  r_e     <= 1'b1;
                  r_state <= S_STOP;
                end else begin
                  r_bit <= w_bit_m1;
                  r_e   <= 1'b1;
                  r_ph  <= 2'd1;
                end
              end
            endcase
          end
        end

        S_CHECK: begin
          if (r_rx == CFG_WORD) begin
            r_ok[r_idx] <= 1'b1;
            r_state     <= S_NEXT;
          end else if (r_retry < RW'(MAX_RETRY)) begin
            r_retry <= r_retry + RW'(1);
            r_rd    <= 1'b0;
            r_ph    <= 2'd0;
            r_tick  <= TICK_LD;
            r_doe   <= 1'b1;
            r_eoe   <= 1'b1;
            r_d     <= 1'b1;
            r_e     <= 1'b1;
            r_state <= S_START;
          end else begin
            r_fail[r_idx] <= 1'b1;
            r_state       <= S_NEXT;
          end
        end

        S_NEXT: begin
          r_retry <= '0;
          if (r_idx == IW'(N_CH - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_cnt   <= PROBE_LD;
            r_state <= S_PROBE;
          end
        end

        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ts4231_multi_cfg.md
TS4231_MULTI_CFG -- requirements
Module: ts4231_multi_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 48_000_000: system clock frequency.
REQ-002 SHALL have parameter N_CH, default 4, range 1..16: number of TS4231 sensor channels.
REQ-003 SHALL have parameter WAIT_US, default 10_000: power-up settle delay, in microseconds.
REQ-004 SHALL have parameter BIT_TICKS, default 12, minimum 2: clk cycles per bus phase step.
REQ-005 SHALL have parameter CFG_WORD, 15 bits, default 15'h392B: configuration word to write.
REQ-006 SHALL have parameter MAX_RETRY, default 2: write/readback retries per channel after the first attempt.
REQ-007 SHALL have parameter PROBE_US, default 100: timeout, in microseconds, for a sensor to show E high.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-010 SHALL have port start, input, 1 bit: single-cycle pulse that begins a configuration run.
REQ-011 SHALL have ports d_in and e_in, input, N_CH bits each: D and E pad levels, already synchronised.
REQ-012 SHALL have ports d_out, d_oe, e_out and e_oe, output, N_CH bits each: pad drive value and drive enable; top level tristates the pad when oe=0.
REQ-013 SHALL have ports busy and cfg_done, output, 1 bit each: run in progress; run complete (held high until the next start or reset).
REQ-014 SHALL have ports ch_ok and ch_fail, output, N_CH bits each: per-channel result.

Function
REQ-015 SHALL derive WAIT_CNT = WAIT_US*(CLK_FREQ_HZ/1_000_000) and PROBE_CNT in the same way; delay counters SHALL be 32 bits and SHALL saturate, never wrap.
REQ-016 SHALL use one shared FSM, serving channels in order 0..N_CH-1: IDLE, PWR_WAIT, PROBE, START, WRITE, STOP, READ, CHECK, NEXT, DONE.
REQ-017 IDLE: all oe=0, busy=0. On start, SHALL clear ch_ok, ch_fail and cfg_done, set the channel index to 0, and go to PWR_WAIT on the next cycle.
REQ-018 PWR_WAIT: SHALL wait exactly WAIT_CNT cycles once per run, not per channel, then go to PROBE.
REQ-019 PROBE: all oe=0. If e_in[idx]=1 is seen within PROBE_CNT cycles, SHALL go to START; otherwise SHALL set ch_fail[idx] and go to NEXT.
REQ-020 Every bus phase step SHALL last BIT_TICKS cycles; only channel idx may have oe=1.
REQ-021 START: drive D=1, E=1, then D=0, then E=0 (3 steps).
REQ-022 WRITE: SHALL send CFG_WORD MSB first, 15 bits; per bit: set D, then E=1, then E=0 (3 steps).
REQ-023 STOP: drive D=0, E=1, then D=1, then release both oe (3 steps).
REQ-024 READ: SHALL perform START, then release D (d_oe=0); per bit, E=1, sample d_in[idx] at the last cycle of the E=1 step, then E=0; SHALL collect 15 bits MSB first, then perform STOP.
REQ-025 CHECK: if the readback equals CFG_WORD, SHALL set ch_ok[idx]; else, if retries < MAX_RETRY, SHALL increment retries and return to START; else SHALL set ch_fail[idx].
REQ-026 NEXT: SHALL clear retries; if idx==N_CH-1, go to DONE, else increment idx and go to PROBE.
REQ-027 DONE: SHALL pulse nothing, set cfg_done=1 and busy=0, then return to IDLE while keeping cfg_done high.
REQ-028 busy SHALL be 1 in every state except IDLE and DONE.
REQ-029 A start asserted while busy=1 SHALL be ignored.
REQ-030 Exactly one of ch_ok[i] or ch_fail[i] SHALL be set per channel by the end of a run.

Reset
REQ-031 While reset=1, on the next clk edge: FSM=IDLE, all d_oe/e_oe/d_out/e_out=0, busy=0, cfg_done=0, ch_ok=0, ch_fail=0, counters and retries=0.
REQ-032 A reset asserted mid-run SHALL release all pads on the following edge, with no partial result retained; reset SHALL take priority over a simultaneous start.

Verification (sim parameters: N_CH=2, WAIT_US=1 giving 48 cycles, PROBE_US=1, BIT_TICKS=4, MAX_RETRY=1)
REQ-033 Both sensor models echo the word; pulse start -> busy rises the next cycle, first e_oe[0] rises 48+ cycles later, cfg_done=1, ch_ok=2'b11, ch_fail=0.
REQ-034 Channel 1 holds e_in low -> ch_fail[1] is set 48 cycles after PROBE entry, ch_ok=2'b01, cfg_done=1.
REQ-035 Channel 0 returns 15'h392A twice -> exactly 2 write sequences are seen on channel 0, ch_fail[0]=1; returns a bad word once then the correct word -> ch_ok[0]=1.
REQ-036 Assert reset during WRITE of channel 0 -> next cycle all oe=0, busy=0; a new start then yields a full correct run.
REQ-037 Pulse start again while busy -> no effect on sequence or timing; check that only one oe channel is active in any cycle (assertion).
